// File: rtl/fifo_rd_stream_adapter_pkg.sv
// Shared definitions for the async-FIFO read-side stream adapter.
// Holds the default word width and the width helper used by the FIFO blocks.
package fifo_rd_stream_adapter_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;
  localparam int unsigned SKID_DEPTH         = 2;

  // Ceiling log2 that stays usable inside constant expressions.
  function automatic int unsigned fifo_clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Two-entry oldest-first buffer between the FIFO read port and the stream.
// Head entry drives the stream; a same-cycle push and pop keeps occupancy.
module fifo_rd_skid_buf
  import fifo_rd_stream_adapter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_din,
  input  logic                  i_pop,
  input  logic                  i_flush,
  output logic [1:0]            o_occ,
  output logic [DATA_WIDTH-1:0] o_head
);

  logic [1:0]            r_occ;
  logic [DATA_WIDTH-1:0] r_d0;
  logic [DATA_WIDTH-1:0] r_d1;
  logic                  w_pop;
  logic                  w_push;

  assign w_pop  = i_pop & (r_occ != 2'd0);
  assign w_push = i_push & (w_pop | (r_occ != 2'(SKID_DEPTH)));

  // Entry 0 is always the oldest word; entry 1 only matters when occ is 2.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      r_occ <= 2'd0;
      r_d0  <= '0;
      r_d1  <= '0;
    end else if (i_flush) begin
      r_occ <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_occ == 2'd0) r_d0 <= i_din;
          else               r_d1 <= i_din;
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          r_d0  <= r_d1;
          r_occ <= r_occ - 2'd1;
        end
        2'b11: begin
          if (r_occ == 2'd1) begin
            r_d0 <= i_din;
          end else begin
            r_d0 <= r_d1;
            r_d1 <= i_din;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_occ  = r_occ;
  assign o_head = r_d0;

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// Read-domain adapter: turns the FIFO registered-read port into a valid/ready
// stream at one beat per cycle, tagging every BURST_LEN-th beat with m_last.
module fifo_rd_stream_adapter
  import fifo_rd_stream_adapter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned BURST_LEN  = 4
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  empty,
  output logic                  r_en,
  input  logic [DATA_WIDTH-1:0] r_data,
  input  logic                  flush,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);

  localparam int unsigned CNT_W = fifo_clog2(BURST_LEN) + 1;

  logic [1:0]       w_occ;
  logic [2:0]       w_need;
  logic             w_pop;
  logic             w_ren;
  logic             w_push;
  logic             r_inflight;
  logic [CNT_W-1:0] r_beat_cnt;

  assign m_valid = (w_occ != 2'd0);
  assign w_pop   = m_valid & m_ready;

  // Issue a pop only if the word is guaranteed a slot when it lands.
  always_comb begin
    w_need = 3'({1'b0, w_occ}) + 3'(r_inflight) - 3'(w_pop);
    w_ren  = ~rrst & ~empty & ~flush & (w_need < 3'(SKID_DEPTH));
  end

  assign r_en = w_ren;

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) r_inflight <= 1'b0;
    else      r_inflight <= w_ren;
  end

  // A word landing on a flush edge is dropped.
  assign w_push = r_inflight & ~flush;

  fifo_rd_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .rclk    (rclk),
    .rrst    (rrst),
    .i_push  (w_push),
    .i_din   (r_data),
    .i_pop   (w_pop),
    .i_flush (flush),
    .o_occ   (w_occ),
    .o_head  (m_data)
  );

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      r_beat_cnt <= '0;
    end else if (flush) begin
      r_beat_cnt <= '0;
    end else if (w_pop) begin
      if (r_beat_cnt == CNT_W'(BURST_LEN - 1)) r_beat_cnt <= '0;
      else                                     r_beat_cnt <= r_beat_cnt + CNT_W'(1);
    end
  end

  assign m_last = m_valid & (r_beat_cnt == CNT_W'(BURST_LEN - 1));

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Bench for fifo_rd_stream_adapter: FIFO environment, queue-based reference
// model, directed vector table, corner-case sequences and random traffic.
module tb_fifo_rd_stream_adapter;

  localparam int unsigned DW = 8;
  localparam int unsigned BL = 4;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  typedef struct {
    logic          ready;
    logic          ev;
    logic [DW-1:0] ed;
    logic          el;
    logic          er;
  } vec_t;

  logic          clk = 1'b0;
  logic          rrst;
  logic          tb_empty = 1'b1;
  logic [DW-1:0] r_data = '0;
  logic          flush;
  logic          m_ready;
  logic          r_en, m_valid, m_last;
  logic [DW-1:0] m_data;
  logic          r_en1, m_valid1, m_last1;
  logic [DW-1:0] m_data1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] fq[$];
  logic [DW-1:0] sb[$];
  beat_t         blog[$];
  int            beat_m = 0;
  logic          infl_m = 1'b0;
  logic [DW-1:0] infl_w = '0;

  always #5 clk = ~clk;

  fifo_rd_stream_adapter #(.DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .rclk(clk), .rrst(rrst), .empty(tb_empty), .r_en(r_en), .r_data(r_data),
    .flush(flush), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  fifo_rd_stream_adapter #(.DATA_WIDTH(DW), .BURST_LEN(1)) dut1 (
    .rclk(clk), .rrst(rrst), .empty(tb_empty), .r_en(r_en1), .r_data(r_data),
    .flush(flush), .m_valid(m_valid1), .m_ready(m_ready), .m_data(m_data1), .m_last(m_last1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // FIFO read port: registered data one cycle after an accepted pop.
  always @(posedge clk) begin
    if (r_en && !tb_empty && fq.size() != 0) r_data <= fq.pop_front();
    tb_empty <= (fq.size() == 0);
  end

  // Reference model: words owned by the adapter, in delivery order.
  always @(negedge clk) begin
    logic ev, pop, er;
    if (rrst) begin
      sb.delete();
      beat_m = 0;
      infl_m = 1'b0;
    end else begin
      ev = (sb.size() != 0);
      chk("m_valid", 32'(m_valid), 32'(ev));
      chk("m_valid_b1", 32'(m_valid1), 32'(ev));
      if (ev) begin
        chk("m_data", 32'(m_data), 32'(sb[0]));
        chk("m_last", 32'(m_last), 32'(beat_m == BL - 1));
        chk("m_data_b1", 32'(m_data1), 32'(sb[0]));
        chk("m_last_b1", 32'(m_last1), 32'd1);
      end
      pop = ev && m_ready;
      er  = !tb_empty && !flush && ((sb.size() + int'(infl_m) - int'(pop)) < 2);
      chk("r_en", 32'(r_en), 32'(er));
      if (r_en && tb_empty) begin
        n_tests++;
        n_fail++;
        $display("FAIL r_en_while_empty: got r_en=1 with empty=1 (t=%0t)", $time);
      end
      if (m_valid && m_ready) blog.push_back({m_data, m_last});
      if (pop) begin
        void'(sb.pop_front());
        beat_m = (beat_m + 1) % BL;
      end
      if (infl_m && !flush) sb.push_back(infl_w);
      if (flush) begin
        sb.delete();
        beat_m = 0;
      end
      infl_m = r_en && !tb_empty;
      infl_w = (fq.size() != 0) ? fq[0] : '0;
    end
  end

  task automatic push_words(input logic [DW-1:0] first, input int n);
    for (int i = 0; i < n; i++) fq.push_back(first + DW'(i));
  endtask

  task automatic chk_log(input string name, input logic [DW-1:0] first, input int n, input int last_phase);
    chk({name, "_count"}, 32'(blog.size()), 32'(n));
    for (int i = 0; i < n && i < blog.size(); i++) begin
      chk({name, "_data"}, 32'(blog[i].d), 32'(first + DW'(i)));
      chk({name, "_last"}, 32'(blog[i].l), 32'(((i + last_phase) % BL) == BL - 1));
    end
  endtask

  vec_t vt[11];
  int   ren_cnt;

  initial begin
    // Streaming 0x10..0x17 from idle, m_ready held high.
    vt[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
    vt[1]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
    vt[2]  = '{1'b1, 1'b1, 8'h10, 1'b0, 1'b1};
    vt[3]  = '{1'b1, 1'b1, 8'h11, 1'b0, 1'b1};
    vt[4]  = '{1'b1, 1'b1, 8'h12, 1'b0, 1'b1};
    vt[5]  = '{1'b1, 1'b1, 8'h13, 1'b1, 1'b1};
    vt[6]  = '{1'b1, 1'b1, 8'h14, 1'b0, 1'b1};
    vt[7]  = '{1'b1, 1'b1, 8'h15, 1'b0, 1'b1};
    vt[8]  = '{1'b1, 1'b1, 8'h16, 1'b0, 1'b0};
    vt[9]  = '{1'b1, 1'b1, 8'h17, 1'b1, 1'b0};
    vt[10] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0};

    rrst = 1'b1; flush = 1'b0; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_r_en", 32'(r_en), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_last", 32'(m_last), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    @(posedge clk); #1 rrst = 1'b0;
    repeat (2) @(posedge clk);

    // Table-driven streaming run.
    blog.delete();
    @(posedge clk); #1;
    push_words(8'h10, 8);
    m_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1 m_ready = vt[i].ready;
      @(negedge clk);
      chk("vec_valid", 32'(m_valid), 32'(vt[i].ev));
      chk("vec_r_en", 32'(r_en), 32'(vt[i].er));
      if (vt[i].ev) begin
        chk("vec_data", 32'(m_data), 32'(vt[i].ed));
        chk("vec_last", 32'(m_last), 32'(vt[i].el));
      end
    end
    repeat (3) @(posedge clk);
    chk_log("stream", 8'h10, 8, 0);

    // Backpressure: stall 5 cycles while 0x12 is at the head.
    blog.delete();
    @(posedge clk); #1;
    push_words(8'h10, 8);
    m_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1 m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_data", 32'(m_data), 32'h12);
      chk("bp_hold_valid", 32'(m_valid), 32'd1);
      chk("bp_r_en_off", 32'(r_en), 32'd0);
      @(posedge clk);
    end
    #1 m_ready = 1'b1;
    repeat (12) @(posedge clk);
    chk_log("bp", 8'h10, 8, 0);

    // Underflow: a single word, then the FIFO stays empty.
    blog.delete();
    ren_cnt = 0;
    @(posedge clk); #1;
    fq.push_back(8'hA5);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (r_en) ren_cnt++;
    end
    chk("uf_r_en_pulses", 32'(ren_cnt), 32'd1);
    chk("uf_beats", 32'(blog.size()), 32'd1);
    if (blog.size() != 0) chk("uf_data", 32'(blog[0].d), 32'hA5);
    chk("uf_valid_after", 32'(m_valid), 32'd0);

    // Flush while a word is in flight and one word is buffered.
    blog.delete();
    @(posedge clk); #1;
    push_words(8'h30, 8);
    m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    chk("fl_r_en_off", 32'(r_en), 32'd0);
    chk("fl_valid_pre", 32'(m_valid), 32'd1);
    @(posedge clk); #1 flush = 1'b0; m_ready = 1'b1;
    @(negedge clk);
    chk("fl_valid_post", 32'(m_valid), 32'd0);
    repeat (12) @(posedge clk);
    chk_log("flush", 8'h32, 6, 0);

    // Asynchronous reset with the buffer full.
    blog.delete();
    @(posedge clk); #1;
    push_words(8'h50, 8);
    m_ready = 1'b0;
    repeat (4) @(posedge clk);
    #1 rrst = 1'b1;
    #1;
    chk("ar_r_en", 32'(r_en), 32'd0);
    chk("ar_m_valid", 32'(m_valid), 32'd0);
    chk("ar_m_last", 32'(m_last), 32'd0);
    chk("ar_m_data", 32'(m_data), 32'd0);
    repeat (2) @(posedge clk);
    #1 rrst = 1'b0; m_ready = 1'b1;
    @(negedge clk);
    chk("ar_valid_release", 32'(m_valid), 32'd0);
    repeat (12) @(posedge clk);
    chk_log("areset", 8'h52, 6, 0);

    // Random traffic against the model.
    begin
      logic [DW-1:0] wv;
      wv = 8'h00;
      for (int i = 0; i < 3000; i++) begin
        @(posedge clk); #1;
        m_ready = ($urandom_range(9) < 7);
        flush   = ($urandom_range(39) == 0);
        if (((i / 200) % 2 == 0) ? ($urandom_range(2) != 0) : ($urandom_range(7) == 0)) begin
          fq.push_back(wv);
          wv = wv + 8'd1;
        end
      end
      @(posedge clk); #1 flush = 1'b0; m_ready = 1'b1;
      repeat (40) @(posedge clk);
      @(negedge clk);
      chk("rnd_fifo_drained", 32'(fq.size()), 32'd0);
      chk("rnd_valid_idle", 32'(m_valid), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
